// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 timing constants and the snake step divisor table.
// The renderer imports the same constants.
package vga_pkg;

    localparam int unsigned CW      = 10;

    localparam int unsigned H_VIS   = 640;
    localparam int unsigned H_FP    = 16;
    localparam int unsigned H_SYNC  = 96;
    localparam int unsigned H_BP    = 48;
    localparam int unsigned H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;

    localparam int unsigned V_VIS   = 480;
    localparam int unsigned V_FP    = 10;
    localparam int unsigned V_SYNC  = 2;
    localparam int unsigned V_BP    = 33;
    localparam int unsigned V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

    // Frames per snake step, indexed by the 2-bit speed select.
    function automatic logic [3:0] speed_to_div(input logic [1:0] speed);
        logic [3:0] div;
        case (speed)
            2'd0:    div = 4'd15;
            2'd1:    div = 4'd10;
            2'd2:    div = 4'd6;
            default: div = 4'd3;
        endcase
        return div;
    endfunction

endpackage

// File: rtl/tick_div_frames.sv
// Frame-synchronous game tick: counts frame starts and pulses every N frames,
// with the divisor select latched only at the frame boundary.
module tick_div_frames
    import vga_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] speed_i,
    input  logic       frame_bound_i,
    input  logic       frame_start_i,
    output logic       game_tick_o
);

    logic [1:0] speed_q, speed_d;
    logic [3:0] fcnt_q,  fcnt_d;
    logic       tick_q,  tick_d;
    logic [3:0] div_last;

    always_comb begin
        speed_d  = frame_bound_i ? speed_i : speed_q;
        div_last = speed_to_div(speed_q) - 4'd1;
        fcnt_d   = fcnt_q;
        tick_d   = 1'b0;
        // >= rather than == so a shrinking divisor still ticks on the next frame
        if (frame_start_i) begin
            if (fcnt_q >= div_last) begin
                fcnt_d = '0;
                tick_d = 1'b1;
            end else begin
                fcnt_d = fcnt_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            speed_q <= '0;
            fcnt_q  <= '0;
            tick_q  <= 1'b0;
        end else begin
            speed_q <= speed_d;
            fcnt_q  <= fcnt_d;
            tick_q  <= tick_d;
        end
    end

    assign game_tick_o = tick_q;

endmodule

// File: rtl/vga_sync_gen.sv
// VGA sync generator: free-running pixel/line counters with registered sync,
// coordinate, active-video and frame-start outputs plus a frame-aligned game tick.
module vga_sync_gen #(
    parameter int unsigned H_VIS  = vga_pkg::H_VIS,
    parameter int unsigned H_FP   = vga_pkg::H_FP,
    parameter int unsigned H_SYNC = vga_pkg::H_SYNC,
    parameter int unsigned H_BP   = vga_pkg::H_BP,
    parameter int unsigned V_VIS  = vga_pkg::V_VIS,
    parameter int unsigned V_FP   = vga_pkg::V_FP,
    parameter int unsigned V_SYNC = vga_pkg::V_SYNC,
    parameter int unsigned V_BP   = vga_pkg::V_BP,
    parameter int unsigned CW     = vga_pkg::CW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    speed,
    output logic          hsync,
    output logic          vsync,
    output logic          video_on,
    output logic [CW-1:0] pixel_x,
    output logic [CW-1:0] pixel_y,
    output logic          frame_start,
    output logic          game_tick
);

    localparam int unsigned H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] H_LAST   = CW'(H_TOT - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOT - 1);
    localparam logic [CW-1:0] H_VIS_C  = CW'(H_VIS);
    localparam logic [CW-1:0] V_VIS_C  = CW'(V_VIS);
    localparam logic [CW-1:0] HS_FIRST = CW'(H_VIS + H_FP);
    localparam logic [CW-1:0] HS_LAST  = CW'(H_VIS + H_FP + H_SYNC - 1);
    localparam logic [CW-1:0] VS_FIRST = CW'(V_VIS + V_FP);
    localparam logic [CW-1:0] VS_LAST  = CW'(V_VIS + V_FP + V_SYNC - 1);

    logic [CW-1:0] h_q, h_d;
    logic [CW-1:0] v_q, v_d;
    logic [CW-1:0] px_q, py_q;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          video_q, video_d;
    logic          fstart_q, fstart_d;
    logic          frame_bound;

    always_comb begin
        h_d = (h_q == H_LAST) ? '0 : h_q + 1'b1;
        v_d = v_q;
        if (h_q == H_LAST) begin
            v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
        end
        frame_bound = (h_q == H_LAST) && (v_q == V_LAST);
        fstart_d    = (h_q == '0) && (v_q == '0);
        hsync_d     = !((h_q >= HS_FIRST) && (h_q <= HS_LAST));
        vsync_d     = !((v_q >= VS_FIRST) && (v_q <= VS_LAST));
        video_d     = (h_q < H_VIS_C) && (v_q < V_VIS_C);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_q      <= '0;
            v_q      <= '0;
            px_q     <= '0;
            py_q     <= '0;
            hsync_q  <= 1'b1;
            vsync_q  <= 1'b1;
            video_q  <= 1'b0;
            fstart_q <= 1'b0;
        end else begin
            h_q      <= h_d;
            v_q      <= v_d;
            px_q     <= h_q;
            py_q     <= v_q;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            video_q  <= video_d;
            fstart_q <= fstart_d;
        end
    end

    // Tick is registered on the same edge as frame_start, so both see the unregistered strobe.
    tick_div_frames u_tick (
        .clk           (clk),
        .rst           (rst),
        .speed_i       (speed),
        .frame_bound_i (frame_bound),
        .frame_start_i (fstart_d),
        .game_tick_o   (game_tick)
    );

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign video_on    = video_q;
    assign pixel_x     = px_q;
    assign pixel_y     = py_q;
    assign frame_start = fstart_q;

endmodule
